// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
//   SEG_BLANK / SEG_DASH : active-low cathode patterns {g,f,e,d,c,b,a}
//   conv_state_t         : load/convert/commit handshake states
//   seg7_decode()        : BCD digit -> active-low segment pattern
//   pow10_minus1()       : largest value representable in a given digit count
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    function automatic longint unsigned pow10_minus1(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per cycle.
//   clk, reset : clock, synchronous active-high reset (aborts any conversion)
//   start      : begin converting bin (ignored while a conversion is running)
//   bin        : binary value, captured on start
//   done       : 1-cycle pulse during the final shift; bcd is valid from the
//                next cycle until the following start
//   bcd        : packed BCD result, digit 0 in bits [3:0]
module bin2bcd_seq #(
    parameter int NUM_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0]          bin_sr;
    logic [4*DIGITS-1:0]       bcd_sr;
    logic [4*DIGITS-1:0]       bcd_adj;
    logic [4*DIGITS+NUM_W-1:0] shifted;
    logic [CNT_W-1:0]          cnt;
    logic                      busy;

    // Add 3 to every digit >= 5 before the shift so that the doubling carries
    // correctly into the next decimal digit.
    always_comb begin
        // NOTE: assign a default first so every path drives bcd_adj; a missing
        // branch in combinational logic would otherwise infer a latch.
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_sr} << 1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            bin_sr <= '0;
            bcd_sr <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            cnt    <= CNT_W'(NUM_W);
            bin_sr <= bin;
            bcd_sr <= '0;
        end else if (busy) begin
            bcd_sr <= shifted[4*DIGITS+NUM_W-1:NUM_W];
            bin_sr <= shifted[NUM_W-1:0];
            cnt    <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (cnt == CNT_W'(1));
    assign bcd  = bcd_sr;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with sequential BCD conversion.
//   clk, reset : clock, synchronous active-high reset
//   number     : binary value, captured on load & ready
//   load       : single-cycle load request
//   en         : 0 turns all anodes off while the scan keeps running
//   dp_in      : per-digit decimal point enable (1 = lit), sampled live
//   ready      : 1 when idle and a load will be accepted
//   overflow   : last committed value did not fit in DIGITS digits
//   anode      : one-hot active-low digit select
//   seg        : active-low cathodes {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_W       = 27,
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_W-1:0]  number,
    input  logic              load,
    input  logic              en,
    input  logic [DIGITS-1:0] dp_in,
    output logic              ready,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int              IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int              PRE_W   = $clog2(REFRESH_DIV);
    localparam longint unsigned MAX_VAL = pow10_minus1(DIGITS);

    conv_state_t         state;
    logic                ovf_pend;
    logic [4*DIGITS-1:0] disp_bcd;
    logic                start;
    logic                conv_done;
    logic [4*DIGITS-1:0] conv_bcd;

    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS-1:0]   blank_mask;
    logic                zero_above;
    logic [3:0]          digit;
    logic [6:0]          seg_nxt;

    assign start = load && ready;

    bin2bcd_seq #(
        .NUM_W  (NUM_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (number),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Handshake: the range check is made at capture time, the result and the
    // overflow flag are committed together one cycle after the last shift, so
    // the display never sees a partially converted value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            overflow <= 1'b0;
            ovf_pend <= 1'b0;
            disp_bcd <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        ovf_pend <= (64'(number) > MAX_VAL);
                        ready    <= 1'b0;
                        state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_bcd <= conv_bcd;
                    overflow <= ovf_pend;
                    ready    <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Refresh prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRE_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Leading-zero mask: walk from the most significant digit down; a digit is
    // blank while every digit at or above it is zero. Digit 0 always shows.
    always_comb begin
        zero_above = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_bcd[4*i +: 4] == 4'd0);
            if (i != 0 && BLANK_LZ) begin
                blank_mask[i] = zero_above;
            end
        end
        digit = disp_bcd[4*idx +: 4];
        if (overflow) begin
            seg_nxt = SEG_DASH;
        end else if (blank_mask[idx]) begin
            seg_nxt = SEG_BLANK;
        end else begin
            seg_nxt = seg7_decode(digit);
        end
    end

    // Anode, cathodes and decimal point all come from the same idx through the
    // same register stage, so they always switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode <= '1;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else begin
            anode <= en ? ~(DIGITS'(1) << idx) : '1;
            seg   <= seg_nxt;
            dp    <= ~dp_in[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_W=27, DIGITS=8, REFRESH_DIV=4).
// Expected digit patterns are pushed when a load is driven and popped when
// the conversion commits and the scan is observed.
module tb_seg7_scan_driver;

    localparam int NUM_W       = 27;
    localparam int DIGITS      = 8;
    localparam int REFRESH_DIV = 4;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic [NUM_W-1:0]  number = '0;
    logic              load   = 1'b0;
    logic              en     = 1'b1;
    logic [DIGITS-1:0] dp_in  = '0;
    logic              ready;
    logic              overflow;
    logic [DIGITS-1:0] anode;
    logic [6:0]        seg;
    logic              dp;

    typedef struct packed {
        logic            ovf;
        logic [7:0][6:0] seg;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    seg7_scan_driver #(
        .NUM_W       (NUM_W),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .number   (number),
        .load     (load),
        .en       (en),
        .dp_in    (dp_in),
        .ready    (ready),
        .overflow (overflow),
        .anode    (anode),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int unsigned d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Reference: a digit above 0 is blank when the value is below 10^d.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned p;
        p = 1;
        e.ovf = (v > 99999999);
        for (int d = 0; d < DIGITS; d++) begin
            if (e.ovf)
                e.seg[d] = 7'h3F;
            else if (d > 0 && v < p)
                e.seg[d] = 7'h7F;
            else
                e.seg[d] = digit_seg((v / p) % 10);
            p = p * 10;
        end
        return e;
    endfunction

    function automatic int anode_digit(input logic [DIGITS-1:0] a);
        for (int d = 0; d < DIGITS; d++) begin
            if (a === ~(8'(1) << d)) return d;
        end
        return -1;
    endfunction

    // Drive a single-cycle load; returns at the negedge right after the
    // capturing edge.
    task automatic do_load(input int unsigned v, input bit accept);
        @(negedge clk);
        number = NUM_W'(v);
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        if (accept) sb_q.push_back(model(v));
    endtask

    task automatic wait_ready(output int lows);
        lows = 0;
        while (ready !== 1'b1 && lows < 200) begin
            lows++;
            @(negedge clk);
        end
        check("ready_returns", 32'(ready), 32'd1);
    endtask

    task automatic scan_check(input string tag);
        exp_t     e;
        bit [7:0] seen;
        int       d;
        e = sb_q.pop_front();
        repeat (2) @(negedge clk);
        check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
        seen = '0;
        for (int s = 0; s < 40; s++) begin
            d = anode_digit(anode);
            if (d >= 0 && !seen[d]) begin
                seen[d] = 1'b1;
                check($sformatf("%s_d%0d", tag, d), 32'(seg), 32'(e.seg[d]));
            end
            @(negedge clk);
        end
        check({tag, "_all_digits"}, 32'(seen), 32'hFF);
    endtask

    initial begin
        int lows;
        int n;
        int bad;
        int dp_lows;
        bit all_off;

        // 1. Reset values and first scan.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_anode", 32'(anode), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_anode", 32'(anode), 32'hFE);
        check("first_seg", 32'(seg), 32'h40);
        check("first_dp", 32'(dp), 32'd1);

        // 2. Full-width value and handshake latency.
        do_load(12345678, 1'b1);
        check("ready_low_after_load", 32'(ready), 32'd0);
        wait_ready(lows);
        check("ready_low_cycles", 32'(lows), 32'd28);
        scan_check("v12345678");

        // 3. Leading-zero blanking.
        do_load(42, 1'b1);
        wait_ready(lows);
        scan_check("v42");
        do_load(0, 1'b1);
        wait_ready(lows);
        scan_check("v0");

        // 4. Overflow and the largest in-range value.
        do_load(100000000, 1'b1);
        wait_ready(lows);
        scan_check("v1e8");
        do_load(99999999, 1'b1);
        wait_ready(lows);
        scan_check("v99999999");

        // 5a. Load while busy is dropped.
        do_load(5, 1'b1);
        @(negedge clk);
        number = NUM_W'(7);
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        wait_ready(lows);
        check("busy_ready_low_cycles", 32'(lows), 32'd26);
        scan_check("busy5");
        check("no_queued_load", 32'(ready), 32'd1);

        // 5b. Reset in the middle of a conversion discards it.
        do_load(9, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_ovf", 32'(overflow), 32'd0);
        sb_q.push_back(model(0));
        scan_check("abort0");
        repeat (30) @(negedge clk);
        check("abort_ready_late", 32'(ready), 32'd1);
        sb_q.push_back(model(0));
        scan_check("abort0_late");

        // 6a. Scan wrap: digit 7 held REFRESH_DIV cycles, then digit 0.
        n = 0;
        while (anode !== 8'h7F && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("wrap_found_d7", 32'(anode), 32'h7F);
        n = 0;
        while (anode === 8'h7F && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("wrap_d7_cycles", 32'(n), 32'(REFRESH_DIV));
        check("wrap_to_d0", 32'(anode), 32'hFE);

        // 6b. en=0 blanks anodes while the index keeps moving; dp follows idx.
        en    = 1'b0;
        dp_in = 8'h04;
        all_off = 1'b1;
        for (int m = 1; m <= 10; m++) begin
            @(negedge clk);
            if (anode !== 8'hFF) all_off = 1'b0;
        end
        check("en0_all_off", 32'(all_off), 32'd1);
        en = 1'b1;
        @(negedge clk);
        check("en1_resume_d2", 32'(anode), 32'hFB);
        bad     = 0;
        dp_lows = 0;
        for (int s = 0; s < 32; s++) begin
            if (anode === 8'hFB) begin
                dp_lows++;
                if (dp !== 1'b0) bad++;
            end else if (dp !== 1'b1) begin
                bad++;
            end
            @(negedge clk);
        end
        check("dp_only_on_d2", 32'(bad), 32'd0);
        check("dp_low_cycles", 32'(dp_lows), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
